// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants and helpers for the multiplexed seven-segment scanner.
// Segment patterns are active-high, ordered a..g with segment a at bit 6.
package seven_seg_pkg;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1111110, // 0
    7'b0110000, // 1
    7'b1101101, // 2
    7'b1111001, // 3
    7'b0110011, // 4
    7'b1011011, // 5
    7'b1011111, // 6
    7'b1110000, // 7
    7'b1111111, // 8
    7'b1111011, // 9
    7'b1110111, // A
    7'b0011111, // b
    7'b1001110, // C
    7'b0111101, // d
    7'b1001111, // E
    7'b1000111  // F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    return SEG_TABLE[h];
  endfunction

  // Width of the slot index counter for a given digit count (N_DIGITS >= 2).
  function automatic int idx_width(input int n_digits);
    return $clog2(n_digits);
  endfunction

endpackage

// File: rtl/scan_timebase.sv
// scan_timebase: prescaler and slot index counters for the display scan.
// slot_wrap marks the last cycle of a slot; frame_end marks the last cycle of a frame.
module scan_timebase
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIV_W    = 17,
  parameter int IW       = idx_width(N_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [DIV_W-1:0] pre,
  output logic [IW-1:0]    idx,
  output logic             slot_wrap,
  output logic             frame_end
);

  localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);

  assign slot_wrap = &pre;
  assign frame_end = slot_wrap && (idx == LAST);

  // Free-running prescaler; slot index steps on every prescaler wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= pre + 1'b1;
      if (slot_wrap) idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed hex display driver with double-buffered
// digit data, per-digit dp/blank, and 16-level brightness PWM.
// Optional build macro: SEVSEG_LZ_BLANK_EN enables leading-zero blanking.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int DIV_W          = 17,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  load,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   digit_sel,
  output logic                  frame_tick
);

  localparam int IW = idx_width(N_DIGITS);

  logic [DIV_W-1:0] pre;
  logic [IW-1:0]    idx;
  logic             slot_wrap;
  logic             frame_end;

  scan_timebase #(.N_DIGITS(N_DIGITS), .DIV_W(DIV_W), .IW(IW)) u_tb (
    .clk       (clk),
    .rst       (rst),
    .pre       (pre),
    .idx       (idx),
    .slot_wrap (slot_wrap),
    .frame_end (frame_end)
  );

  logic [N_DIGITS-1:0][3:0] pend_digits, act_digits;
  logic [N_DIGITS-1:0]      pend_dp, act_dp;
  logic [N_DIGITS-1:0]      pend_blank, act_blank;

  // Pending buffer: last load in a frame wins; cleared to dark on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '1;
    end else if (load) begin
      pend_digits <= digits;
      pend_dp     <= dp;
      pend_blank  <= blank;
    end
  end

  // Active buffer only moves at frame boundaries, so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_digits <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
    end else if (frame_end) begin
      act_digits <= pend_digits;
      act_dp     <= pend_dp;
      act_blank  <= pend_blank;
    end
  end

  logic [N_DIGITS-1:0] lz_blank;

`ifdef SEVSEG_LZ_BLANK_EN
  logic lz_run;
  // Blank zero digits from the top down until a nonzero nibble or set dp; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (lz_run && (act_digits[i] == 4'h0) && !act_dp[i]) lz_blank[i] = 1'b1;
      else                                                  lz_run      = 1'b0;
    end
  end
`else
  assign lz_blank = '0;
`endif

  logic [N_DIGITS-1:0] eff_blank;
  logic                pwm_on;
  logic                lit;
  logic [6:0]          seg_int;
  logic                dp_int;
  logic [N_DIGITS-1:0] sel_int;

  assign eff_blank = act_blank | lz_blank;
  assign pwm_on    = (brightness == 4'hF) || (pre[DIV_W-1 -: 4] < brightness);

  // Active-high view of the current slot; a dark digit drives nothing at all.
  always_comb begin
    lit     = !eff_blank[idx] && pwm_on;
    seg_int = '0;
    dp_int  = 1'b0;
    sel_int = '0;
    if (lit) begin
      seg_int = hex_to_seg(act_digits[idx]);
      dp_int  = act_dp[idx];
      sel_int = N_DIGITS'(1) << idx;
    end
  end

  // Output stage: select and segments share one register so they switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out    <= {7{SEG_ACTIVE_LOW}};
      dp_out     <= SEG_ACTIVE_LOW;
      digit_sel  <= {N_DIGITS{SEL_ACTIVE_LOW}};
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_int ^ {7{SEG_ACTIVE_LOW}};
      dp_out     <= dp_int ^ SEG_ACTIVE_LOW;
      digit_sel  <= sel_int ^ {N_DIGITS{SEL_ACTIVE_LOW}};
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: randomized + directed stimulus checked every cycle against
// an arithmetic reference model (slot/frame position derived from a cycle count).
module tb_seven_seg_scanner;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int S  = 1 << DW;   // cycles per slot
  localparam int F  = N * S;     // cycles per frame

  logic          clk = 1'b0;
  logic          rst;
  logic [4*N-1:0] digits;
  logic [N-1:0]  dp, blank;
  logic          load;
  logic [3:0]    brightness;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [N-1:0]  digit_sel;
  logic          frame_tick;

  always #5 clk = ~clk;

  seven_seg_scanner #(.N_DIGITS(N), .DIV_W(DW), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp         (dp),
    .blank      (blank),
    .load       (load),
    .brightness (brightness),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  int          c;                 // cycles since reset
  logic [15:0] p_d, a_d;
  logic [3:0]  p_dp, a_dp, p_bl, a_bl;
  logic [6:0]  e_seg;
  logic        e_dp, e_ft;
  logic [3:0]  e_sel;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [3:0] lz_mask(input logic [15:0] d, input logic [3:0] p);
    logic [3:0] m = 4'h0;
`ifdef SEVSEG_LZ_BLANK_EN
    for (int i = N - 1; i >= 1; i--) begin
      if (((d >> (4 * i)) & 16'hF) == 16'h0 && !p[i]) m[i] = 1'b1;
      else break;
    end
`endif
    return m;
  endfunction

  task automatic model_update();
    int pre, idx;
    logic lit;
    logic [3:0] eb, nib;
    if (rst) begin
      c = 0;
      p_d = '0; a_d = '0; p_dp = '0; a_dp = '0; p_bl = '1; a_bl = '1;
      e_seg = 7'h7F; e_dp = 1'b1; e_sel = 4'hF; e_ft = 1'b0;
    end else begin
      pre = c % S;
      idx = (c / S) % N;
      eb  = a_bl | lz_mask(a_d, a_dp);
      lit = !eb[idx] && (brightness == 4'd15 || (pre >> (DW - 4)) < int'(brightness));
      nib = 4'((a_d >> (4 * idx)) & 16'hF);
      e_seg = ~(lit ? seg_of(nib) : 7'h00);
      e_dp  = ~(lit & a_dp[idx]);
      e_sel = ~(lit ? 4'(1 << idx) : 4'h0);
      e_ft  = (pre == S - 1) && (idx == N - 1);
      if (e_ft) begin a_d = p_d; a_dp = p_dp; a_bl = p_bl; end
      if (load) begin p_d = digits; p_dp = dp; p_bl = blank; end
      c++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("seg_out", 32'(seg_out), 32'(e_seg));
    chk("dp_out", 32'(dp_out), 32'(e_dp));
    chk("digit_sel", 32'(digit_sel), 32'(e_sel));
    chk("frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    digits = d; dp = p; blank = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; digits = '0; dp = '0; blank = '0; brightness = 4'd15;
    step(); step();
    rst = 1'b0;

    // Idle: dark display, frame ticks only
    repeat (200) step();

    // Basic load, full brightness
    do_load(16'h1A3F, 4'b0100, 4'b0000);
    repeat (150) step();

    // Load just before a boundary, then coincident with the next boundary
    while (c % F != F - 4) step();
    do_load(16'h2468, 4'b0001, 4'b0000);
    while (c % F != F - 1) step();
    do_load(16'h9BCD, 4'b1000, 4'b0010);
    repeat (140) step();

    // Brightness PWM
    brightness = 4'd4;
    repeat (130) step();
    brightness = 4'd0;
    repeat (70) step();
    brightness = 4'd15;

    // Leading zeros
    do_load(16'h0050, 4'b0000, 4'b0000);
    repeat (140) step();

    // Reset mid slot 2 with pending data outstanding
    do_load(16'h7777, 4'b1111, 4'b0000);
    while (c % F != 2 * S + 7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (150) step();

    // Random traffic
    repeat (3000) begin
      load   = ($urandom_range(0, 19) == 0);
      digits = 16'($urandom);
      dp     = 4'($urandom);
      blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 49) == 0) brightness = 4'($urandom);
      rst    = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
